// File: rtl/shreg_serdes_ctrl.sv
// ---------------------------------------------------------------------------
// shreg_serdes_ctrl
//
// Sequencer that drives an external N-bit universal shift register as a
// half-duplex serializer/deserializer. A parallel word taken on the s_*
// handshake is loaded into the register. The register is then shifted
// exactly N times, one shift per DIV-cycle bit period. The captured word is
// offered on the m_* handshake.
//
// Optional build macro: SHREG_LOOPBACK_EN
//   When defined, the bit shifted into the register is the bit leaving it
//   (ser_out) rather than ser_in. The register rotates, so the received word
//   equals the transmitted word.
// ---------------------------------------------------------------------------
module shreg_serdes_ctrl #(
    parameter int N   = 8,
    parameter int DIV = 4,
    parameter int CW  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    input  logic         s_dir,
    input  logic         ser_in,
    output logic         ser_out,
    output logic         ser_strobe,
    output logic         busy,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_d,
    input  logic [N-1:0] sr_q
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_SHL  = 2'b01;
    localparam logic [1:0] CMD_SHR  = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;

    localparam logic [CW-1:0] PER_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] bit_cnt;
    logic          dir_q;

    logic          accept;
    logic          shift_now;
    logic          fb_bit;

    assign accept    = (state == ST_IDLE) && s_valid;
    assign shift_now = (state == ST_SHIFT) && (per_cnt == PER_LAST);

    assign s_ready    = (state == ST_IDLE);
    assign busy       = (state == ST_SHIFT) || (state == ST_DONE);
    assign m_valid    = (state == ST_DONE);
    assign m_data     = sr_q;
    assign ser_strobe = shift_now;

    // Bit leaving the register on the next shift; quiet outside a frame.
    always_comb begin
        ser_out = 1'b0;
        if (state == ST_SHIFT) begin
            ser_out = dir_q ? sr_q[0] : sr_q[N-1];
        end
    end

`ifdef SHREG_LOOPBACK_EN
    assign fb_bit = ser_out;
`else
    assign fb_bit = ser_in;
`endif

    // Register command is combinational so the register acts on the same edge.
    always_comb begin
        sr_ctrl = CMD_HOLD;
        sr_d    = '0;
        if (accept) begin
            sr_ctrl = CMD_LOAD;
            sr_d    = s_data;
        end else if (shift_now) begin
            if (dir_q) begin
                sr_ctrl = CMD_SHR;
                sr_d    = {fb_bit, {(N-1){1'b0}}};
            end else begin
                sr_ctrl = CMD_SHL;
                sr_d    = {{(N-1){1'b0}}, fb_bit};
            end
        end
    end

    // Frame sequencing: load, N timed shifts, then hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            per_cnt <= '0;
            bit_cnt <= '0;
            dir_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        state   <= ST_SHIFT;
                        per_cnt <= '0;
                        bit_cnt <= '0;
                        dir_q   <= s_dir;
                    end
                end
                ST_SHIFT: begin
                    if (per_cnt == PER_LAST) begin
                        per_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/shreg_serdes_ctrl.md
Name: shreg_serdes_ctrl

Overview:
Sequencer for an external N-bit universal shift register, turning it into a half-duplex serializer/deserializer. It accepts a parallel word over a valid/ready handshake and loads it into the register. It then performs exactly N shifts in the requested direction at a programmable bit rate, emitting one serial bit and capturing one serial bit per shift. The captured word is presented on a second valid/ready handshake.

Parameters:
N, 8, data width of the shift register (N >= 2)
DIV, 4, clock cycles per bit period (DIV >= 1); one shift occurs in the last cycle of each period
CW, 16, width of bit-period and bit counters (must hold max(DIV-1, N))

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  parallel word to transmit is valid
s_ready  out  1  block accepts word (high only in IDLE)
s_data  in  N  word to load
s_dir  in  1  0 = shift left (MSB first out), 1 = shift right (LSB first out); sampled at accept
ser_in  in  1  serial input bit
ser_out  out  1  serial output bit (bit currently leaving the register)
ser_strobe  out  1  one-cycle pulse in the cycle a shift is commanded
busy  out  1  high in LOAD-accepted through DONE
m_valid  out  1  received word valid
m_ready  in  1  consumer accepts received word
m_data  out  N  received word (equals sr_q while in DONE)
sr_ctrl  out  2  register command: 00 hold, 01 shift left (sr_d[0] enters LSB), 10 shift right (sr_d[N-1] enters MSB), 11 load sr_d
sr_d  out  N  register data input
sr_q  in  N  register contents

Behaviour:
- Interface: clock clk; reset rst, asynchronous, active-high.
- Reset: state=IDLE, counters=0, latched dir=0. Outputs: s_ready=1, m_valid=0, busy=0, ser_strobe=0, sr_ctrl=00, sr_d=0, ser_out=0.
- sr_ctrl and sr_d are combinational from state, counters and inputs, so the register acts on the same clock edge.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: sr_ctrl=11, sr_d=s_data, latch s_dir, clear counters, go to SHIFT.
  - Otherwise sr_ctrl=00.
- SHIFT:
  - Period counter counts 0..DIV-1.
  - When the period counter equals DIV-1:
    - ser_strobe=1.
    - sr_ctrl=01 if left, with sr_d[0]=ser_in and other bits 0.
    - sr_ctrl=10 if right, with sr_d[N-1]=ser_in and other bits 0.
    - Bit counter increments; period counter wraps to 0.
  - Other cycles: sr_ctrl=00.
  - After the N-th shift, go to DONE.
  - DIV=1 gives a shift every cycle, N consecutive strobes.
- ser_out: sr_q[N-1] if left, sr_q[0] if right; valid throughout SHIFT and held stable for the whole bit period.
- DONE:
  - sr_ctrl=00, m_valid=1, m_data=sr_q.
  - On m_ready, go to IDLE. m_valid falls the next cycle.
  - s_ready stays 0 until back in IDLE, so there is no overlap.
- Latency: accept edge to first strobe is DIV cycles. Accept to m_valid is N*DIV+1 cycles.
- An s_dir change after accept is ignored. s_data and s_dir are ignored while s_ready=0.
- An m_ready high outside DONE has no effect.
- rst asserted mid-frame: immediately IDLE, frame discarded, no m_valid. The register contents are not cleared by this block.
- Bit counter never exceeds N; no wrap past N.

Optional Feature:
SHREG_LOOPBACK_EN
- Defined: the serial bit fed into sr_d is ser_out instead of ser_in, so the register rotates; after N shifts m_data equals the loaded word. ser_in is ignored. ser_out and ser_strobe still toggle externally.
- Undefined: ser_in is used as described above.

Test Plan:
1. Reset: N=8, DIV=4, assert rst mid-cycle -> outputs at reset values immediately; s_ready=1 after release.
2. Left frame: s_data=8'hC1, s_dir=0, ser_in=1 -> load at accept edge; ser_out per bit period = 1,1,0,0,0,0,0,1; 8 strobes spaced 4 cycles; m_valid at accept+33; m_data=8'hFF.
3. Right frame: DIV=1, s_data=8'hC1, s_dir=1, ser_in=0 -> ser_out per cycle = 1,0,0,0,0,0,1,1; 8 back-to-back strobes; m_data=8'h00.
4. Backpressure: hold m_ready=0 for 10 cycles in DONE with s_valid=1 -> m_valid and m_data stable, s_ready=0, no new load; m_ready=1 -> IDLE next cycle, next word accepted.
5. Abort: assert rst after 3 strobes -> no m_valid; a new frame afterwards completes normally with a correct count of 8 strobes.
6. With SHREG_LOOPBACK_EN: s_data=8'h5A in each direction -> m_data=8'h5A; ser_in toggling has no effect.
